feed_arbiter: RTL and testbench



---
 rtl/feed_arb_pkg.sv | 30 +++
 rtl/rr_pick_comb.sv | 23 ++
 rtl/feed_arbiter.sv | 140 ++++++++++++++
 tb/tb_feed_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/feed_arb_pkg.sv
// feed_arb_pkg: shared constants and the round-robin pick helper for feed_arbiter.
package feed_arb_pkg;

  localparam int DEF_NUM_FEEDS      = 4;
  localparam int DEF_GAP_CYCLES     = 2;
  localparam int DEF_TIMEOUT_CYCLES = 64;
  localparam int MAX_FEEDS          = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // First requester at or after ptr, wrapping modulo n. Scanning from the far
  // end lets the closest requester overwrite the result last.
  function automatic logic [2:0] rr_pick(input logic [MAX_FEEDS-1:0] req,
                                         input logic [2:0] ptr,
                                         input int n);
    int idx;
    logic [2:0] pick;
    pick = '0;
    for (int i = MAX_FEEDS - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = (int'(ptr) + i) % n;
        if (req[3'(idx)]) pick = 3'(idx);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// rr_pick_comb: combinational round-robin priority encoder.
module rr_pick_comb
  import feed_arb_pkg::*;
#(
  parameter  int NUM_FEEDS = DEF_NUM_FEEDS,
  localparam int FIDW      = $clog2(NUM_FEEDS)
) (
  input  logic [NUM_FEEDS-1:0] req,
  input  logic [FIDW-1:0]      ptr,
  output logic [FIDW-1:0]      grant,
  output logic                 any_req
);

  logic [2:0] pick;

  // Search from ptr upward and report whether anyone is asking at all.
  always_comb begin
    pick    = rr_pick(MAX_FEEDS'(req), 3'(ptr), NUM_FEEDS);
    grant   = FIDW'(pick);
    any_req = |req;
  end

endmodule

// File: rtl/feed_arbiter.sv
// feed_arbiter: packet-granular round-robin arbiter in front of the parse chain.
// One feed owns the output for a whole frame; a fixed idle gap follows each frame.
// Optional stall watchdog built when FEED_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | no grant; pick the next requester from rr_ptr
// XFER    | granted feed streams bytes until its last byte
// GAP     | forced idle cycles so the parser returns to its header state
module feed_arbiter
  import feed_arb_pkg::*;
#(
  parameter  int NUM_FEEDS      = DEF_NUM_FEEDS,
  parameter  int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int FIDW           = $clog2(NUM_FEEDS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_FEEDS*8-1:0] feed_data,
  input  logic [NUM_FEEDS-1:0]   feed_valid,
  input  logic [NUM_FEEDS-1:0]   feed_last,
  output logic [NUM_FEEDS-1:0]   feed_ready,
  output logic [7:0]             data_out,
  output logic                   valid_out,
  output logic                   last_out,
  output logic [FIDW-1:0]        grant_id,
  output logic                   busy,
  output logic                   abort_out
);

  logic [1:0]      state;
  logic [FIDW-1:0] rr_ptr;
  logic [FIDW-1:0] pick;
  logic            any_req;
  logic [3:0]      gap_cnt;
  logic [7:0]      lane [NUM_FEEDS];
  logic [7:0]      sel_data;
  logic            sel_valid;
  logic            sel_last;
  logic            accept;
  logic            stall_hit;
  logic [FIDW-1:0] next_ptr;

  rr_pick_comb #(.NUM_FEEDS(NUM_FEEDS)) u_pick (
    .req     (feed_valid),
    .ptr     (rr_ptr),
    .grant   (pick),
    .any_req (any_req)
  );

  // Split the flat data bus into per-feed byte lanes.
  always_comb begin
    for (int i = 0; i < NUM_FEEDS; i++) lane[i] = feed_data[8*i +: 8];
  end

  // Mux the granted feed and decide whether its byte is taken this cycle.
  always_comb begin
    sel_data  = lane[grant_id];
    sel_valid = feed_valid[grant_id];
    sel_last  = feed_last[grant_id];
    accept    = (state == ST_XFER) && sel_valid;
    next_ptr  = (grant_id == FIDW'(NUM_FEEDS - 1)) ? '0 : grant_id + FIDW'(1);
  end

  // Only the granted feed sees ready, and only while transferring.
  always_comb begin
    feed_ready = '0;
    if (state == ST_XFER) feed_ready[grant_id] = 1'b1;
  end

  assign busy = (state == ST_XFER) || (state == ST_GAP);

`ifdef FEED_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TOW-1:0] stall_cnt;
  logic           abort_q;

  assign stall_hit = (state == ST_XFER) && !accept &&
                     (stall_cnt == TOW'(TIMEOUT_CYCLES - 1));
  assign abort_out = abort_q;

  // Count consecutive mid-frame cycles without a byte; fire once at the limit.
  always_ff @(posedge clk) begin
    if (rst || state != ST_XFER || accept) stall_cnt <= '0;
    else                                   stall_cnt <= stall_cnt + TOW'(1);
    abort_q <= !rst && stall_hit;
  end
`else
  // Watchdog not built: a stalled feed keeps the grant. The parameter is kept
  // so both builds share one interface; the compare is constant false.
  assign stall_hit = 1'b0;
  assign abort_out = (TIMEOUT_CYCLES < 0);
`endif

  // Register each accepted byte toward the parser (one-cycle latency).
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
    end else begin
      valid_out <= accept;
      last_out  <= accept && sel_last;
      if (accept) data_out <= sel_data;
    end
  end

  // Arbitration FSM with the post-frame gap down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant_id <= pick;
            state    <= ST_XFER;
          end
        end
        ST_XFER: begin
          if ((accept && sel_last) || stall_hit) begin
            rr_ptr  <= next_ptr;
            gap_cnt <= 4'(GAP_CYCLES - 1);
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) state <= ST_IDLE;
          else               gap_cnt <= gap_cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_feed_arbiter.sv
// tb_feed_arbiter: directed bench for feed_arbiter (4 feeds, gap 2, timeout 8).
module tb_feed_arbiter;

  localparam int NF = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NF*8-1:0] feed_data;
  logic [NF-1:0] feed_valid;
  logic [NF-1:0] feed_last;
  logic [NF-1:0] feed_ready;
  logic [7:0]    data_out;
  logic          valid_out;
  logic          last_out;
  logic [1:0]    grant_id;
  logic          busy;
  logic          abort_out;

  int n_checks = 0;
  int n_errors = 0;

  // per-feed frame source: bytes fbase, fbase+1, ... with last on byte flen-1
  logic [7:0] fbase [NF];
  int         flen  [NF];
  int         fidx  [NF];
  logic       fen   [NF];
  logic       fonce [NF];

  always #5 clk = ~clk;

  feed_arbiter #(.NUM_FEEDS(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .feed_data  (feed_data),
    .feed_valid (feed_valid),
    .feed_last  (feed_last),
    .feed_ready (feed_ready),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .last_out   (last_out),
    .grant_id   (grant_id),
    .busy       (busy),
    .abort_out  (abort_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NF; i++) begin
      feed_valid[i]        = fen[i];
      feed_data[8*i +: 8]  = fbase[i] + 8'(fidx[i]);
      feed_last[i]         = (fidx[i] == flen[i] - 1);
    end
  endtask

  task automatic set_frame(input int i, input logic [7:0] base, input int len, input logic once);
    fbase[i] = base;
    flen[i]  = len;
    fidx[i]  = 0;
    fen[i]   = 1'b1;
    fonce[i] = once;
  endtask

  // one clock; sources advance only on bytes the arbiter actually took
  task automatic tick();
    logic [NF-1:0] acc;
    acc = feed_ready & feed_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < NF; i++) begin
      if (acc[i]) begin
        if (fidx[i] == flen[i] - 1) begin
          fidx[i] = 0;
          if (fonce[i]) fen[i] = 1'b0;
        end else begin
          fidx[i] = fidx[i] + 1;
        end
      end
    end
    drive();
  endtask

  task automatic check_byte(input string tag, input logic [7:0] d, input logic l);
    check({tag, "_valid"}, valid_out, 1'b1);
    check({tag, "_data"}, data_out, d);
    check({tag, "_last"}, last_out, l);
  endtask

  initial begin
    rst = 1'b1;
    feed_data = '0;
    feed_valid = '0;
    feed_last = '0;
    for (int i = 0; i < NF; i++) begin
      fbase[i] = 8'h00; flen[i] = 1; fidx[i] = 0; fen[i] = 1'b0; fonce[i] = 1'b1;
    end
    drive();

    // reset values
    tick(); tick();
    check("rst_data", data_out, 8'h00);
    check("rst_valid", valid_out, 1'b0);
    check("rst_last", last_out, 1'b0);
    check("rst_ready", feed_ready, 4'b0000);
    check("rst_grant", grant_id, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_abort", abort_out, 1'b0);
    rst = 1'b0;
    tick();
    check("idle_busy", busy, 1'b0);

    // single feed, 5 bytes 0x11..0x15
    set_frame(0, 8'h11, 5, 1'b1); drive();
    tick();
    check("s1_grant", grant_id, 2'd0);
    check("s1_ready", feed_ready, 4'b0001);
    check("s1_arb_novalid", valid_out, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_byte("s1_byte", 8'h11 + 8'(k), k == 4);
    end
    check("s1_gap_ready", feed_ready, 4'b0000);
    check("s1_gap_busy", busy, 1'b1);
    tick();
    check("s1_gap1_valid", valid_out, 1'b0);
    check("s1_gap1_busy", busy, 1'b1);
    tick();
    check("s1_gap2_valid", valid_out, 1'b0);
    check("s1_idle_busy", busy, 1'b0);
    check("s1_grant_end", grant_id, 2'd0);

    // contention: feeds 1 and 3 from rr_ptr=0
    rst = 1'b1; tick(); rst = 1'b0;
    set_frame(1, 8'hA1, 3, 1'b1); set_frame(3, 8'hC1, 3, 1'b1); drive();
    tick();
    check("s2_grant1", grant_id, 2'd1);
    check("s2_ready1", feed_ready, 4'b0010);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_byte("s2_f1", 8'hA1 + 8'(k), k == 2);
      if (k < 2) check("s2_f3_held", feed_ready, 4'b0010);
    end
    check("s2_gap_ready", feed_ready, 4'b0000);
    tick();
    check("s2_gap_valid", valid_out, 1'b0);
    tick();
    check("s2_idle_busy", busy, 1'b0);
    tick();
    check("s2_grant3", grant_id, 2'd3);
    check("s2_ready3", feed_ready, 4'b1000);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_byte("s2_f3", 8'hC1 + 8'(k), k == 2);
    end
    tick(); tick();

    // fairness: all four request continuously, 2-byte frames
    for (int i = 0; i < NF; i++) set_frame(i, 8'h41 + 8'(16 * i), 2, 1'b0);
    drive();
    for (int f = 0; f < 5; f++) begin
      int g;
      g = f % 4;
      tick();
      check("s3_grant", grant_id, 32'(g));
      check("s3_ready", feed_ready, 32'(1 << g));
      check("s3_arb_novalid", valid_out, 1'b0);
      tick();
      check_byte("s3_b0", 8'h41 + 8'(16 * g), 1'b0);
      tick();
      check_byte("s3_b1", 8'h42 + 8'(16 * g), 1'b1);
      if (f == 4) begin
        for (int i = 0; i < NF; i++) fen[i] = 1'b0;
        drive();
      end
      tick();
      check("s3_gap_valid", valid_out, 1'b0);
      check("s3_gap_busy", busy, 1'b1);
      tick();
      check("s3_idle_valid", valid_out, 1'b0);
      check("s3_idle_busy", busy, 1'b0);
    end

    // bubbles: feed 2 drops valid for 4 cycles mid-frame
    set_frame(2, 8'h81, 6, 1'b1); drive();
    tick();
    check("s4_grant", grant_id, 2'd2);
    tick(); check_byte("s4_b0", 8'h81, 1'b0);
    tick(); check_byte("s4_b1", 8'h82, 1'b0);
    fen[2] = 1'b0; drive();
    for (int s = 0; s < 4; s++) begin
      tick();
      check("s4_bubble_valid", valid_out, 1'b0);
      check("s4_bubble_grant", grant_id, 2'd2);
      check("s4_bubble_ready", feed_ready, 4'b0100);
    end
    fen[2] = 1'b1; drive();
    for (int k = 2; k < 6; k++) begin
      tick();
      check_byte("s4_rest", 8'h81 + 8'(k), k == 5);
    end
    tick(); tick();

    // reset mid-frame after 2 of 6 bytes
    set_frame(0, 8'h91, 6, 1'b1); drive();
    tick();
    check("s5_grant", grant_id, 2'd0);
    tick(); check_byte("s5_b0", 8'h91, 1'b0);
    tick(); check_byte("s5_b1", 8'h92, 1'b0);
    rst = 1'b1;
    tick();
    check("s5_rst_data", data_out, 8'h00);
    check("s5_rst_valid", valid_out, 1'b0);
    check("s5_rst_last", last_out, 1'b0);
    check("s5_rst_ready", feed_ready, 4'b0000);
    check("s5_rst_grant", grant_id, 2'd0);
    check("s5_rst_busy", busy, 1'b0);
    rst = 1'b0;
    set_frame(0, 8'hD1, 3, 1'b1); drive();
    tick();
    check("s5_regrant", grant_id, 2'd0);
    check("s5_reready", feed_ready, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_byte("s5_new", 8'hD1 + 8'(k), k == 2);
    end
    tick(); tick();

    // stall of feed 1 mid-frame with feed 2 waiting
    set_frame(1, 8'hE1, 4, 1'b1); set_frame(2, 8'hF1, 2, 1'b1); drive();
    tick();
    check("s6_grant1", grant_id, 2'd1);
    tick(); check_byte("s6_b0", 8'hE1, 1'b0);
    tick(); check_byte("s6_b1", 8'hE2, 1'b0);
    fen[1] = 1'b0; drive();
`ifdef FEED_TIMEOUT_EN
    for (int s = 1; s <= 8; s++) begin
      tick();
      check("s6_abort", abort_out, s == 8);
      check("s6_stall_valid", valid_out, 1'b0);
    end
    check("s6_abort_ready", feed_ready, 4'b0000);
    check("s6_abort_busy", busy, 1'b1);
    tick();
    check("s6_abort_pulse", abort_out, 1'b0);
    tick();
    check("s6_idle_busy", busy, 1'b0);
`else
    for (int s = 1; s <= 12; s++) begin
      tick();
      check("s6_noabort", abort_out, 1'b0);
      check("s6_hold_grant", grant_id, 2'd1);
      check("s6_hold_ready", feed_ready, 4'b0010);
    end
    fen[1] = 1'b1; drive();
    tick(); check_byte("s6_b2", 8'hE3, 1'b0);
    tick(); check_byte("s6_b3", 8'hE4, 1'b1);
    tick(); tick();
    check("s6_idle_busy", busy, 1'b0);
`endif
    tick();
    check("s6_grant2", grant_id, 2'd2);
    check("s6_ready2", feed_ready, 4'b0100);
    tick(); check_byte("s6_f2b0", 8'hF1, 1'b0);
    tick(); check_byte("s6_f2b1", 8'hF2, 1'b1);
    tick(); tick();
    check("end_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
